// File: rtl/mic_packet_tx.sv
// Microphone sample FIFO feeding a framed packet transmitter: one header frame
// followed by BURST data frames, with SILENCE substituted when the FIFO runs dry.
module mic_packet_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BURST      = 4,
    parameter logic [7:0]  HDR_TAG    = 8'hC7,
    parameter logic [7:0]  DATA_TAG   = 8'hC6,
    parameter logic [31:0] SILENCE    = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        record_active,
    input  logic [31:0] mic_data,
    input  logic        mic_data_valid,
    output logic        mic_data_retrieved,
    input  logic        tx_req,
    output logic [39:0] tx_frame,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  underrun_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_BEAT = 4'(BURST - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [39:0]   tx_frame_q, tx_frame_d;
    logic          tx_valid_q, tx_valid_d;
    logic          from_fifo_q, from_fifo_d;
    logic [3:0]    beat_q, beat_d;
    logic [7:0]    underrun_q, underrun_d;
    logic          retrieved_q, retrieved_d;
    logic          holdoff_q, holdoff_d;
    logic          busy_q, busy_d;

    logic          push, pop, load, underrun_inc, accept, flush;
    logic [CW-1:0] cnt_after_pop;
    logic [AW-1:0] rd_after_pop;

    // Capture, FIFO bookkeeping and packet sequencing.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        tx_frame_d    = tx_frame_q;
        tx_valid_d    = tx_valid_q;
        from_fifo_d   = from_fifo_q;
        beat_d        = beat_q;
        underrun_d    = underrun_q;
        pop           = 1'b0;
        load          = 1'b0;
        underrun_inc  = 1'b0;

        flush  = !record_active;
        accept = tx_valid_q && tx_ready;
        push   = mic_data_valid && (count_q != FULL_CNT) && record_active && !holdoff_q;

        case (state_q)
            IDLE: begin
                if (tx_req) begin
                    state_d     = HDR;
                    tx_valid_d  = 1'b1;
                    tx_frame_d  = {HDR_TAG, 8'(BURST), 8'(count_q), underrun_q, 8'h00};
                    from_fifo_d = 1'b0;
                    beat_d      = 4'd0;
                end
            end
            HDR: begin
                if (accept) begin
                    state_d = DATA;
                    load    = 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    pop = from_fifo_q && !flush;
                    if (beat_q == LAST_BEAT) begin
                        state_d     = IDLE;
                        tx_valid_d  = 1'b0;
                        from_fifo_d = 1'b0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                        load   = 1'b1;
                    end
                end else if (flush && from_fifo_q) begin
                    // A flush invalidates a stalled FIFO word; the rest of the packet is silence.
                    tx_frame_d   = {DATA_TAG, SILENCE};
                    from_fifo_d  = 1'b0;
                    underrun_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_after_pop = count_q - CW'(pop);
        rd_after_pop  = rd_ptr_q + AW'(pop);

        if (load) begin
            if (!flush && (cnt_after_pop != '0)) begin
                tx_frame_d  = {DATA_TAG, mem_q[rd_after_pop]};
                from_fifo_d = 1'b1;
            end else begin
                tx_frame_d   = {DATA_TAG, SILENCE};
                from_fifo_d  = 1'b0;
                underrun_inc = 1'b1;
            end
        end

        if (underrun_inc && (underrun_q != 8'hFF)) begin
            underrun_d = underrun_q + 8'd1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_after_pop;
            count_d  = count_q + CW'(push) - CW'(pop);
        end

        retrieved_d = push;
        holdoff_d   = push;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_frame_q  <= '0;
            tx_valid_q  <= 1'b0;
            from_fifo_q <= 1'b0;
            beat_q      <= 4'd0;
            underrun_q  <= 8'd0;
            retrieved_q <= 1'b0;
            holdoff_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_frame_q  <= tx_frame_d;
            tx_valid_q  <= tx_valid_d;
            from_fifo_q <= from_fifo_d;
            beat_q      <= beat_d;
            underrun_q  <= underrun_d;
            retrieved_q <= retrieved_d;
            holdoff_q   <= holdoff_d;
            busy_q      <= busy_d;
        end
    end

    // Sample storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= mic_data;
        end
    end

    assign mic_data_retrieved = retrieved_q;
    assign tx_frame           = tx_frame_q;
    assign tx_valid           = tx_valid_q;
    assign busy               = busy_q;
    assign underrun_count     = underrun_q;

endmodule

// File: tb/tb_mic_packet_tx.sv
// Directed bench for mic_packet_tx: capture handshake, packet framing, underruns,
// back-pressure, flush and asynchronous reset.
module tb_mic_packet_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        record_active;
    logic [31:0] mic_data;
    logic        mic_data_valid;
    logic        mic_data_retrieved;
    logic        tx_req;
    logic [39:0] tx_frame;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  underrun_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mic_packet_tx dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .record_active      (record_active),
        .mic_data           (mic_data),
        .mic_data_valid     (mic_data_valid),
        .mic_data_retrieved (mic_data_retrieved),
        .tx_req             (tx_req),
        .tx_frame           (tx_frame),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .underrun_count     (underrun_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        logic got;
        got            = 1'b0;
        mic_data       = w;
        mic_data_valid = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = mic_data_retrieved;
        end
        mic_data_valid = 1'b0;
        chk("push_ack", 64'(got), 64'd1);
        @(negedge clk);
    endtask

    task automatic send_req();
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
    endtask

    // Full packet with tx_ready held high; d holds the four payloads, first in [127:96].
    task automatic run_packet(input string tag, input logic [39:0] hdr, input logic [127:0] d);
        tx_ready = 1'b1;
        send_req();
        chk($sformatf("%s_hdr", tag), 64'({tx_valid, busy, tx_frame}), 64'({2'b11, hdr}));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("%s_d%0d", tag, i), 64'({tx_valid, tx_frame}),
                64'({1'b1, 8'hC6, d[127-32*i -: 32]}));
        end
        @(negedge clk);
        chk($sformatf("%s_end", tag), 64'({tx_valid, busy}), 64'd0);
    endtask

    initial begin
        logic [39:0] exp36 [5];
        logic        r36 [8];
        int          idx;
        int          pulses;
        int          adjacent;
        logic        prev;

        rst_n          = 1'b0;
        record_active  = 1'b1;
        mic_data       = 32'h0;
        mic_data_valid = 1'b0;
        tx_req         = 1'b0;
        tx_ready       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_frame", 64'(tx_frame), 64'd0);
        chk("rst_busy_ack", 64'({busy, mic_data_retrieved}), 64'd0);
        chk("rst_underrun", 64'(underrun_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic packet from four buffered words.
        push_word(32'h12345678);
        push_word(32'h9ABCDEF0);
        push_word(32'h11111111);
        push_word(32'h22222222);
        run_packet("basic", 40'hC7_04040000, {32'h12345678, 32'h9ABCDEF0, 32'h11111111, 32'h22222222});

        // Empty FIFO: all silence, underruns counted and reported in the next header.
        run_packet("empty1", 40'hC7_04000000, {4{32'hFFFFFFFF}});
        chk("underrun_4", 64'(underrun_count), 64'd4);
        run_packet("empty2", 40'hC7_04000400, {4{32'hFFFFFFFF}});
        chk("underrun_8", 64'(underrun_count), 64'd8);

        // Held valid: one acknowledge every other cycle until full.
        pulses         = 0;
        adjacent       = 0;
        prev           = 1'b0;
        mic_data       = 32'hA5A5A5A5;
        mic_data_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mic_data_retrieved) pulses++;
            if (mic_data_retrieved && prev) adjacent++;
            prev = mic_data_retrieved;
        end
        mic_data_valid = 1'b0;
        chk("ack_pulses", 64'(pulses), 64'd8);
        chk("ack_adjacent", 64'(adjacent), 64'd0);
        @(negedge clk);
        run_packet("full", 40'hC7_04080800, {4{32'hA5A5A5A5}});

        // Flush the four leftovers, then back-pressure with a stray request mid-packet.
        record_active = 1'b0;
        @(negedge clk);
        record_active = 1'b1;
        @(negedge clk);
        push_word(32'hAAAA0001);
        push_word(32'hAAAA0002);
        push_word(32'hAAAA0003);
        push_word(32'hAAAA0004);
        exp36[0] = 40'hC7_04040800;
        exp36[1] = 40'hC6_AAAA0001;
        exp36[2] = 40'hC6_AAAA0002;
        exp36[3] = 40'hC6_AAAA0003;
        exp36[4] = 40'hC6_AAAA0004;
        r36      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        idx      = 0;
        tx_ready = 1'b0;
        send_req();
        chk("bp_hdr", 64'({tx_valid, tx_frame}), 64'({1'b1, exp36[0]}));
        for (int i = 0; i < 8; i++) begin
            tx_ready = r36[i];
            tx_req   = (i == 3);
            @(negedge clk);
            tx_req = 1'b0;
            if (r36[i]) idx++;
            if (idx < 5) chk($sformatf("bp_step%0d", i), 64'({tx_valid, tx_frame}), 64'({1'b1, exp36[idx]}));
            else         chk($sformatf("bp_step%0d", i), 64'({tx_valid, busy}), 64'd0);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_queue", 64'({tx_valid, busy}), 64'd0);

        // Recording stops while the second data frame is accepted.
        push_word(32'hBBBB0001);
        push_word(32'hBBBB0002);
        push_word(32'hBBBB0003);
        push_word(32'hBBBB0004);
        tx_ready = 1'b1;
        send_req();
        chk("fl_hdr", 64'(tx_frame), 64'h00C7_04040800);
        @(negedge clk);
        chk("fl_d1", 64'(tx_frame), 64'h00C6_BBBB0001);
        @(negedge clk);
        chk("fl_d2", 64'(tx_frame), 64'h00C6_BBBB0002);
        record_active = 1'b0;
        @(negedge clk);
        chk("fl_d3", 64'({tx_valid, tx_frame}), 64'({1'b1, 40'hC6_FFFFFFFF}));
        record_active = 1'b1;
        @(negedge clk);
        chk("fl_d4", 64'({tx_valid, tx_frame}), 64'({1'b1, 40'hC6_FFFFFFFF}));
        @(negedge clk);
        chk("fl_end", 64'({tx_valid, underrun_count}), 64'h0A);
        send_req();
        chk("fl_count0", 64'(tx_frame), 64'h00C7_04000A00);

        // Asynchronous reset in the middle of a packet.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'({tx_valid, busy}), 64'd0);
        chk("arst_underrun", 64'(underrun_count), 64'd0);
        chk("arst_frame", 64'(tx_frame), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_no_frames", 64'({tx_valid, busy}), 64'd0);
        run_packet("post_rst", 40'hC7_04000000, {4{32'hFFFFFFFF}});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
